// File: rtl/uart_rx_frame.sv
// ---------------------------------------------------------------------------
// uart_rx_frame
//   UART receiver matching the team's UART transmitter framing and parity.
//   The serial line is oversampled at prescale x baud. Each bit is decided by
//   a 3-point majority vote around the bit centre. Data arrives LSB first.
//   Parity and stop bit are checked, and each good frame delivers one
//   parallel byte.
//
// Ports
//   clk         oversampling clock (prescale x baud)
//   rst         asynchronous, active-low reset
//   rx_in       serial line, idles high, asynchronous to clk
//   prescale    oversampling ratio 8/16/32 (anything else behaves as 8)
//   par_en      1 = parity bit follows the data bits
//   par_typ     1 = even parity, 0 = odd parity
//   p_data      last good received word
//   data_valid  one-cycle strobe: p_data updated
//   par_err     one-cycle strobe: parity mismatch
//   stp_err     one-cycle strobe: stop bit sampled low
// ---------------------------------------------------------------------------
module uart_rx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [5:0]            prescale,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e                state_q,    state_d;
  logic                  sync1_q,    sync2_q;
  logic [5:0]            edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0]      bit_cnt_q,  bit_cnt_d;
  logic [5:0]            presc_q,    presc_d;
  logic                  par_en_q,   par_en_d;
  logic                  par_typ_q,  par_typ_d;
  logic [2:0]            samp_q,     samp_d;
  logic [DATA_WIDTH-1:0] shift_q,    shift_d;
  logic                  par_flag_q, par_flag_d;
  logic [DATA_WIDTH-1:0] p_data_q,   p_data_d;
  logic                  dv_q,       dv_d;
  logic                  pe_q,       pe_d;
  logic                  se_q,       se_d;

  logic                  rxs;
  logic [5:0]            last_edge;
  logic [5:0]            mid;
  logic                  bit_end;
  logic                  vote;
  logic                  exp_par;
  logic                  stop_bad;
  logic [DATA_WIDTH:0]   shift_in;

  assign rxs       = sync2_q;
  assign last_edge = presc_q - 6'd1;
  assign mid       = {1'b0, presc_q[5:1]};
  assign bit_end   = (edge_cnt_q == last_edge);
  assign vote      = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) |
                     (samp_q[1] & samp_q[2]);
  assign exp_par   = par_typ_q ? ^shift_q : ~^shift_q;
  assign stop_bad  = ~vote;
  // The voted bit enters at the MSB; after DATA_WIDTH bits the first
  // (LSB-first) line bit has reached bit 0.
  assign shift_in  = {vote, shift_q};

  always_comb begin
    // NOTE: every signal assigned here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d    = state_q;
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    presc_d    = presc_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    samp_d     = samp_q;
    shift_d    = shift_q;
    par_flag_d = par_flag_q;
    p_data_d   = p_data_q;
    dv_d       = 1'b0;
    pe_d       = 1'b0;
    se_d       = 1'b0;

    if (state_q != IDLE) begin
      edge_cnt_d = bit_end ? 6'd0 : edge_cnt_q + 6'd1;
      if (edge_cnt_q == mid - 6'd1) samp_d[0] = rxs;
      if (edge_cnt_q == mid)        samp_d[1] = rxs;
      if (edge_cnt_q == mid + 6'd1) samp_d[2] = rxs;
    end

    unique case (state_q)
      IDLE: begin
        edge_cnt_d = 6'd0;
        bit_cnt_d  = '0;
        if (!rxs) begin
          // The detect cycle is edge 0 of the start bit, so START begins at
          // edge 1. This keeps frames exactly 10 (or 11) bit periods long and
          // lets a start bit directly after a stop bit be taken without slip.
          state_d    = START;
          edge_cnt_d = 6'd1;
          presc_d    = (prescale == 6'd16 || prescale == 6'd32) ? prescale : 6'd8;
          par_en_d   = par_en;
          par_typ_d  = par_typ;
        end
      end
      START: begin
        if (bit_end) state_d = vote ? IDLE : DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_in[DATA_WIDTH:1];
          if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          if (vote != exp_par) par_flag_d = 1'b1;
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d    = IDLE;
          pe_d       = par_flag_q;
          se_d       = stop_bad;
          dv_d       = ~par_flag_q & ~stop_bad;
          if (dv_d) p_data_d = shift_q;
          par_flag_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated only with non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      presc_q    <= 6'd8;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      samp_q     <= '0;
      shift_q    <= '0;
      par_flag_q <= 1'b0;
      p_data_q   <= '0;
      dv_q       <= 1'b0;
      pe_q       <= 1'b0;
      se_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= rx_in;
      sync2_q    <= sync1_q;
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      presc_q    <= presc_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      samp_q     <= samp_d;
      shift_q    <= shift_d;
      par_flag_q <= par_flag_d;
      p_data_q   <= p_data_d;
      dv_q       <= dv_d;
      pe_q       <= pe_d;
      se_q       <= se_d;
    end
  end

  assign p_data     = p_data_q;
  assign data_valid = dv_q;
  assign par_err    = pe_q;
  assign stp_err    = se_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_frame
//   Self-checking bench for uart_rx_frame. Each sent frame pushes its
//   expected outcome (byte, data_valid, par_err, stp_err) to a scoreboard
//   queue; a monitor pops one entry per strobe cycle and compares.
// ---------------------------------------------------------------------------
module tb_uart_rx_frame;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic [5:0] prescale;
  logic       par_en;
  logic       par_typ;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  uart_rx_frame #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .prescale   (prescale),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       dv;
    logic       pe;
    logic       se;
  } exp_t;

  exp_t       sb_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         dv_cyc = 0;
  int         prev_dv_cyc = 0;
  logic [7:0] last_good = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every strobe cycle must match the oldest expected frame.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1 && (data_valid || par_err || stp_err)) begin
      if (data_valid) begin
        prev_dv_cyc = dv_cyc;
        dv_cyc      = cyc;
      end
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_strobe: dv=%b pe=%b se=%b p_data=%h, required no strobe",
                 data_valid, par_err, stp_err, p_data);
      end else begin
        e = sb_q.pop_front();
        checks++;
        if (data_valid !== e.dv) begin
          errors++;
          $display("FAIL data_valid: got %b, expected %b", data_valid, e.dv);
        end
        checks++;
        if (par_err !== e.pe) begin
          errors++;
          $display("FAIL par_err: got %b, expected %b", par_err, e.pe);
        end
        checks++;
        if (stp_err !== e.se) begin
          errors++;
          $display("FAIL stp_err: got %b, expected %b", stp_err, e.se);
        end
        checks++;
        if (p_data !== e.data) begin
          errors++;
          $display("FAIL p_data: got %h, expected %h", p_data, e.data);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance n clocks, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b, input int p);
    rx_in = b;
    tick(p);
  endtask

  task automatic push_expect(input logic [7:0] d, input logic pen,
                             input logic ptyp, input logic pbit,
                             input logic sbit);
    exp_t e;
    logic exp_par;
    exp_par = ptyp ? ^d : ~^d;
    e.pe    = pen && (pbit !== exp_par);
    e.se    = (sbit == 1'b0);
    e.dv    = !e.pe && !e.se;
    if (e.dv) last_good = d;
    e.data  = last_good;
    sb_q.push_back(e);
  endtask

  // Sends one frame using the current prescale/par_en/par_typ. corrupt_bit
  // selects a data bit whose centre oversample is inverted (-1 = none);
  // scramble changes the configuration inputs while the frame is in flight.
  task automatic send_frame(input logic [7:0] d, input logic pbit,
                            input logic sbit, input int corrupt_bit,
                            input bit scramble);
    int         p;
    logic       pen;
    logic       ptyp;
    logic [5:0] psc;
    psc  = prescale;
    p    = int'(prescale);
    pen  = par_en;
    ptyp = par_typ;
    push_expect(d, pen, ptyp, pbit, sbit);
    drive_bit(1'b0, p);
    if (scramble) begin
      prescale = 6'd32;
      par_en   = ~pen;
      par_typ  = ~ptyp;
    end
    for (int i = 0; i < 8; i++) begin
      if (i == corrupt_bit) begin
        rx_in = d[i];
        tick(p / 2);
        rx_in = ~d[i];
        tick(1);
        rx_in = d[i];
        tick(p - p / 2 - 1);
      end else begin
        drive_bit(d[i], p);
      end
    end
    if (pen) drive_bit(pbit, p);
    drive_bit(sbit, p);
    rx_in    = 1'b1;
    prescale = psc;
    par_en   = pen;
    par_typ  = ptyp;
  endtask

  task automatic wait_drain(input string name, input int limit);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < limit) begin
      tick(1);
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d frames still pending after %0d cycles, expected 0",
               name, sb_q.size(), limit);
      sb_q.delete();
    end
    tick(4);
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if (p_data !== 8'h00 || data_valid !== 1'b0 || par_err !== 1'b0 || stp_err !== 1'b0) begin
      errors++;
      $display("FAIL %s: p_data=%h dv=%b pe=%b se=%b, expected all 0",
               name, p_data, data_valid, par_err, stp_err);
    end
  endtask

  task automatic test_reset();
    rst      = 1'b0;
    rx_in    = 1'b1;
    prescale = 6'd8;
    par_en   = 1'b0;
    par_typ  = 1'b0;
    #1;
    check_outputs_zero("reset_async");
    tick(3);
    check_outputs_zero("reset_held");
    rst = 1'b1;
    tick(4);
    check_outputs_zero("reset_released");
  endtask

  task automatic test_prescale8();
    int fall_cyc;
    prescale = 6'd8;
    par_en   = 1'b0;
    fall_cyc = cyc;
    send_frame(8'hA5, 1'b0, 1'b1, -1, 1'b1);
    wait_drain("prescale8", 200);
    checks++;
    if (dv_cyc - fall_cyc != 10 * 8 + 2) begin
      errors++;
      $display("FAIL prescale8_latency: got %0d cycles, expected %0d",
               dv_cyc - fall_cyc, 10 * 8 + 2);
    end
  endtask

  task automatic test_parity16();
    prescale = 6'd16;
    par_en   = 1'b1;
    par_typ  = 1'b1;
    send_frame(8'hA5, 1'b0, 1'b1, -1, 1'b0);
    send_frame(8'hA5, 1'b1, 1'b1, -1, 1'b0);
    wait_drain("parity16", 400);
  endtask

  task automatic test_stop32();
    prescale = 6'd32;
    par_en   = 1'b1;
    par_typ  = 1'b0;
    send_frame(8'h3C, 1'b1, 1'b0, -1, 1'b0);
    wait_drain("stop32", 600);
  endtask

  task automatic test_glitch();
    prescale = 6'd16;
    par_en   = 1'b0;
    rx_in    = 1'b0;
    tick(3);
    rx_in    = 1'b1;
    tick(24);
    checks++;
    if (dut.state_q !== 3'd0) begin
      errors++;
      $display("FAIL glitch_idle: state=%0d, expected 0 (IDLE)", dut.state_q);
    end
    tick(16);
    send_frame(8'h5A, 1'b0, 1'b1, -1, 1'b0);
    wait_drain("glitch", 300);
  endtask

  task automatic test_back_to_back();
    prescale = 6'd8;
    par_en   = 1'b0;
    send_frame(8'hFF, 1'b0, 1'b1, -1, 1'b0);
    send_frame(8'h00, 1'b0, 1'b1, -1, 1'b0);
    wait_drain("back_to_back", 300);
    checks++;
    if (dv_cyc - prev_dv_cyc != 80) begin
      errors++;
      $display("FAIL back_to_back_gap: got %0d cycles, expected 80", dv_cyc - prev_dv_cyc);
    end
  endtask

  task automatic test_majority_and_reset();
    prescale = 6'd8;
    par_en   = 1'b0;
    send_frame(8'h81, 1'b0, 1'b1, 0, 1'b0);
    wait_drain("majority", 200);
    // Partial frame: start bit plus three data bits, then reset mid-bit.
    drive_bit(1'b0, 8);
    drive_bit(1'b1, 8);
    drive_bit(1'b0, 8);
    drive_bit(1'b1, 8);
    tick(3);
    rst = 1'b0;
    #1;
    last_good = 8'h00;
    check_outputs_zero("midframe_reset_outputs");
    checks++;
    if (dut.state_q !== 3'd0) begin
      errors++;
      $display("FAIL midframe_reset_state: state=%0d, expected 0 (IDLE)", dut.state_q);
    end
    rx_in = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(40);
    send_frame(8'h3C, 1'b0, 1'b1, -1, 1'b0);
    wait_drain("after_reset", 200);
  endtask

  initial begin
    test_reset();
    test_prescale8();
    test_parity16();
    test_stop32();
    test_glitch();
    test_back_to_back();
    test_majority_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
